// File: rtl/nec_ir_transmitter.sv
// NEC infrared frame encoder: leader, 32 data bits, stop mark, or a repeat code.
// Drives a carrier-modulated LED output and also exposes the raw mark/space envelope.
module nec_ir_transmitter #(
  parameter int CLOCK_SPEED      = 50_000_000,
  parameter int CARRIER_HZ       = 38_000,
  parameter int CARRIER_DUTY_DIV = 3
) (
  input  logic        clkIN,
  input  logic        resetIN,
  input  logic        startIN,
  input  logic        repeatIN,
  input  logic [31:0] dataIN,
  output logic        busyOUT,
  output logic        doneOUT,
  output logic        envelopeOUT,
  output logic        txOUT,
  output logic [2:0]  dbgStateOUT
);

  localparam longint T_L = longint'(CLOCK_SPEED) * 9 / 16000;
  localparam int     T   = int'(T_L);
  localparam int     P   = CLOCK_SPEED / CARRIER_HZ;
  localparam int     PH  = P / CARRIER_DUTY_DIV;
  localparam int     DW  = $clog2(16 * T + 1);
  localparam int     CW  = (P > 1) ? $clog2(P) : 1;

  localparam logic [DW-1:0] D_LEAD   = DW'(16 * T - 1);
  localparam logic [DW-1:0] D_LSPACE = DW'(8 * T - 1);
  localparam logic [DW-1:0] D_RSPACE = DW'(4 * T - 1);
  localparam logic [DW-1:0] D_ONE    = DW'(T - 1);
  localparam logic [DW-1:0] D_THREE  = DW'(3 * T - 1);
  localparam logic [CW-1:0] C_LAST   = CW'(P - 1);
  localparam logic [CW-1:0] C_HIGH   = CW'(PH);
  localparam logic          TX_FIRST = (PH > 0);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LEAD_MARK  = 3'd1,
    S_LEAD_SPACE = 3'd2,
    S_BIT_MARK   = 3'd3,
    S_BIT_SPACE  = 3'd4,
    S_REP_SPACE  = 3'd5,
    S_STOP_MARK  = 3'd6
  } state_t;

  state_t        r_state;
  logic [DW-1:0] r_cnt;
  logic [CW-1:0] r_car;
  logic [4:0]    r_idx;
  logic [31:0]   r_data;
  logic          r_rep;
  logic          r_busy;
  logic          r_done;
  logic          r_env;
  logic          r_tx;

  logic          w_cnt_zero;
  logic          w_cur_bit;
  logic [CW-1:0] w_car_next;
  logic          w_car_high_next;

  assign w_cnt_zero      = (r_cnt == '0);
  // Bytes go out most-significant first, each byte LSB first.
  assign w_cur_bit       = r_data[{~r_idx[4:3], r_idx[2:0]}];
  assign w_car_next      = (r_car == C_LAST) ? '0 : r_car + CW'(1);
  assign w_car_high_next = (w_car_next < C_HIGH);

  always_ff @(posedge clkIN or posedge resetIN) begin
    if (resetIN) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_car   <= '0;
      r_idx   <= '0;
      r_data  <= '0;
      r_rep   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_env   <= 1'b0;
      r_tx    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (startIN || repeatIN) begin
            r_state <= S_LEAD_MARK;
            r_rep   <= !startIN;
            if (startIN) r_data <= dataIN;
            r_cnt   <= D_LEAD;
            r_busy  <= 1'b1;
            r_env   <= 1'b1;
            r_car   <= '0;
            r_tx    <= TX_FIRST;
          end
        end
        S_LEAD_MARK: begin
          if (w_cnt_zero) begin
            r_state <= r_rep ? S_REP_SPACE : S_LEAD_SPACE;
            r_cnt   <= r_rep ? D_RSPACE : D_LSPACE;
            r_env   <= 1'b0;
            r_tx    <= 1'b0;
          end else begin
            r_cnt <= r_cnt - DW'(1);
            r_car <= w_car_next;
            r_tx  <= w_car_high_next;
          end
        end
        S_LEAD_SPACE: begin
          if (w_cnt_zero) begin
            r_state <= S_BIT_MARK;
            r_idx   <= '0;
            r_cnt   <= D_ONE;
            r_env   <= 1'b1;
            r_car   <= '0;
            r_tx    <= TX_FIRST;
          end else begin
            r_cnt <= r_cnt - DW'(1);
          end
        end
        S_BIT_MARK: begin
          if (w_cnt_zero) begin
            r_state <= S_BIT_SPACE;
            r_cnt   <= w_cur_bit ? D_THREE : D_ONE;
            r_env   <= 1'b0;
            r_tx    <= 1'b0;
          end else begin
            r_cnt <= r_cnt - DW'(1);
            r_car <= w_car_next;
            r_tx  <= w_car_high_next;
          end
        end
        S_BIT_SPACE: begin
          if (w_cnt_zero) begin
            r_state <= (r_idx == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
            r_idx   <= r_idx + 5'd1;
            r_cnt   <= D_ONE;
            r_env   <= 1'b1;
            r_car   <= '0;
            r_tx    <= TX_FIRST;
          end else begin
            r_cnt <= r_cnt - DW'(1);
          end
        end
        S_REP_SPACE: begin
          if (w_cnt_zero) begin
            r_state <= S_STOP_MARK;
            r_cnt   <= D_ONE;
            r_env   <= 1'b1;
            r_car   <= '0;
            r_tx    <= TX_FIRST;
          end else begin
            r_cnt <= r_cnt - DW'(1);
          end
        end
        S_STOP_MARK: begin
          if (w_cnt_zero) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_env   <= 1'b0;
            r_tx    <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - DW'(1);
            r_car <= w_car_next;
            r_tx  <= w_car_high_next;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busyOUT     = r_busy;
  assign doneOUT     = r_done;
  assign envelopeOUT = r_env;
  assign txOUT       = r_tx;
  assign dbgStateOUT = r_state;

endmodule

// File: tb/tb_nec_ir_transmitter.sv
// Bench for nec_ir_transmitter: requests go into an expected queue, an envelope
// decoder pops and checks each finished frame against a timing/payload model.
module tb_nec_ir_transmitter;

  localparam int CS = 32000;
  localparam int CH = 4000;
  localparam int DD = 3;
  localparam int T  = CS * 9 / 16000;
  localparam int P  = CS / CH;
  localparam int PH = P / DD;
  localparam int W  = 57;

  logic        clkIN = 1'b0;
  logic        resetIN;
  logic        startIN;
  logic        repeatIN;
  logic [31:0] dataIN;
  logic        busyOUT;
  logic        doneOUT;
  logic        envelopeOUT;
  logic        txOUT;
  logic [2:0]  dbgStateOUT;

  int n_checks = 0;
  int n_fail   = 0;

  // {is_repeat, busy_cycles[23:0], payload[31:0]}
  logic [W-1:0] exp_q[$];

  nec_ir_transmitter #(
    .CLOCK_SPEED(CS),
    .CARRIER_HZ(CH),
    .CARRIER_DUTY_DIV(DD)
  ) dut (
    .clkIN(clkIN),
    .resetIN(resetIN),
    .startIN(startIN),
    .repeatIN(repeatIN),
    .dataIN(dataIN),
    .busyOUT(busyOUT),
    .doneOUT(doneOUT),
    .envelopeOUT(envelopeOUT),
    .txOUT(txOUT),
    .dbgStateOUT(dbgStateOUT)
  );

  always #5 clkIN = ~clkIN;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int frame_cycles(input logic [31:0] d);
    int ones;
    ones = $countones(d);
    return (24 + 2 * (32 - ones) + 4 * ones + 1) * T;
  endfunction

  // Waits for IDLE, scrambling the request inputs while busy, then issues one request.
  task automatic send(input logic [31:0] d, input bit rep, input bit both);
    int guard;
    guard = 0;
    @(negedge clkIN);
    while (busyOUT && guard < 5000) begin
      startIN  = ($urandom_range(0, 7) == 0);
      repeatIN = ($urandom_range(0, 7) == 0);
      dataIN   = $urandom;
      @(negedge clkIN);
      guard++;
    end
    if (guard >= 5000) check("send_wait_idle_timeout", 64'(guard), 64'd0);
    startIN  = !rep || both;
    repeatIN = rep || both;
    dataIN   = d;
    if (rep && !both) exp_q.push_back({1'b1, 24'(21 * T), 32'h0});
    else              exp_q.push_back({1'b0, 24'(frame_cycles(d)), d});
    @(negedge clkIN);
    startIN  = 1'b0;
    repeatIN = 1'b0;
    dataIN   = $urandom;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 10000) begin
      @(negedge clkIN);
      guard++;
    end
    check("drain_pending", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clkIN);
  endtask

  int       runs[$];
  int       cur_len;
  logic     cur_lvl;
  int       busy_len;
  int       mark_pos;
  int       car_err;
  bit       rec_active = 1'b0;
  bit       prev_done  = 1'b0;

  task automatic finalize();
    logic [W-1:0] e;
    logic [31:0]  got;
    bit           shape_ok;
    runs.push_back(cur_len);
    check("expected_pending", 64'(exp_q.size() > 0), 64'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("busy_len", 64'(busy_len), 64'(e[55:32]));
      check("carrier_errors", 64'(car_err), 64'd0);
      if (e[56]) begin
        shape_ok = (runs.size() == 3) && (runs[0] == 16 * T) && (runs[1] == 4 * T) && (runs[2] == T);
        check("repeat_shape", 64'(shape_ok), 64'd1);
      end else begin
        got = '0;
        shape_ok = (runs.size() == 67);
        if (shape_ok) begin
          if (runs[0] != 16 * T || runs[1] != 8 * T || runs[66] != T) shape_ok = 1'b0;
          for (int i = 0; i < 32; i++) begin
            if (runs[2 + 2 * i] != T) shape_ok = 1'b0;
            if (runs[3 + 2 * i] == 3 * T) got[(3 - i / 8) * 8 + i % 8] = 1'b1;
            else if (runs[3 + 2 * i] != T) shape_ok = 1'b0;
          end
        end
        check("frame_shape", 64'(shape_ok), 64'd1);
        check("payload", 64'(got), 64'(e[31:0]));
      end
    end
  endtask

  always @(negedge clkIN) begin
    if (resetIN) begin
      rec_active = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (doneOUT) begin
        check("done_width", 64'(prev_done), 64'd0);
        check("done_idle_outputs", 64'({busyOUT, envelopeOUT, txOUT}), 64'd0);
        check("done_with_frame", 64'(rec_active), 64'd1);
        if (rec_active) finalize();
        rec_active = 1'b0;
      end
      if (busyOUT) begin
        if (!rec_active) begin
          rec_active = 1'b1;
          runs.delete();
          cur_lvl  = 1'b1;
          cur_len  = 0;
          busy_len = 0;
          car_err  = 0;
          mark_pos = 0;
          check("accept_env_tx", 64'({envelopeOUT, txOUT}), 64'b11);
        end
        busy_len++;
        if (envelopeOUT == cur_lvl) cur_len++;
        else begin
          runs.push_back(cur_len);
          cur_lvl = envelopeOUT;
          cur_len = 1;
        end
        if (envelopeOUT) begin
          if (cur_len == 1) mark_pos = 0;
          if (txOUT != ((mark_pos % P) < PH)) car_err++;
          mark_pos++;
        end else if (txOUT) begin
          car_err++;
        end
      end else if (rec_active) begin
        check("busy_end_with_done", 64'(doneOUT), 64'd1);
        rec_active = 1'b0;
      end
      prev_done = doneOUT;
    end
  end

  initial begin
    resetIN  = 1'b1;
    startIN  = 1'b1;
    repeatIN = 1'b0;
    dataIN   = 32'h00ff02fd;
    repeat (5) @(negedge clkIN);
    check("reset_busy", 64'(busyOUT), 64'd0);
    check("reset_done", 64'(doneOUT), 64'd0);
    check("reset_env", 64'(envelopeOUT), 64'd0);
    check("reset_tx", 64'(txOUT), 64'd0);
    startIN = 1'b0;
    resetIN = 1'b0;
    repeat (3) @(negedge clkIN);
    check("idle_after_reset", 64'({busyOUT, envelopeOUT}), 64'd0);

    send(32'h00ff02fd, 1'b0, 1'b0);
    drain();
    send(32'h0, 1'b1, 1'b0);
    drain();
    send(32'ha5a51234, 1'b0, 1'b1);
    send(32'h00000000, 1'b0, 1'b0);
    send(32'hffffffff, 1'b0, 1'b0);
    drain();

    for (int i = 0; i < 8; i++) begin
      send($urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
    end
    drain();

    send(32'hdeadbeef, 1'b0, 1'b0);
    repeat (16 * T + 3) @(posedge clkIN);
    #3;
    resetIN = 1'b1;
    exp_q.delete();
    #1;
    check("midreset_outputs", 64'({busyOUT, doneOUT, envelopeOUT, txOUT}), 64'd0);
    repeat (3) @(negedge clkIN);
    resetIN = 1'b0;
    repeat (4 * T) @(negedge clkIN);
    check("midreset_stays_idle", 64'({busyOUT, doneOUT, envelopeOUT}), 64'd0);
    send(32'h00ff02fd, 1'b0, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
